uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the UART receiver.
- Captures each received word on the receiver's one-cycle ready strobe, tagged with its parity-error flag.
- Presents words to the consumer through a valid/ready stream.
- Drives an RTS_n flow-control output with hysteresis and keeps saturating overflow/error statistics, so software or a bus bridge can drain bytes without losing the 1-cycle strobe.

Parameters:
- DATA_WIDTH, 8, width of received word; matches receiver data width.
- DEPTH, 16, total entry capacity; power of 2, >= 4.
- RTS_HIGH, 12, level at or above which rts_n deasserts (goes high); 1..DEPTH.
- RTS_LOW, 8, level at or below which rts_n reasserts (goes low); 0..RTS_HIGH-1.
- DROP_ERRORS, 0, 1 = words arriving with rx_error are discarded (counted, not stored).
- STAT_WIDTH, 8, width of saturating statistic counters.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous, active-high reset.
- rx_data, in, DATA_WIDTH, word from receiver; sampled only when rx_ready=1.
- rx_ready, in, 1, one-cycle strobe, word valid.
- rx_error, in, 1, parity error flag, coincident with rx_ready.
- m_data, out, DATA_WIDTH, head word.
- m_error, out, 1, error tag of head word.
- m_valid, out, 1, head word available.
- m_ready, in, 1, consumer accepts head when m_valid&&m_ready.
- level, out, $clog2(DEPTH)+1, entries held.
- rts_n, out, 1, 0 = peer may send, 1 = hold off.
- overflow, out, 1, sticky, a word was lost to full FIFO.
- overflow_count, out, STAT_WIDTH, saturating count of lost words.
- error_count, out, STAT_WIDTH, saturating count of words received with rx_error (stored or dropped).
- clear_stats, in, 1, clears overflow, overflow_count, error_count.

Behaviour:
- Reset values: all pointers 0; level 0; m_valid 0; m_data 0; m_error 0; rts_n 0; overflow 0; both counters 0. rst overrides every other input in the same cycle, including mid-stream: buffered contents are discarded.
- Storage: circular array, read/write pointers $clog2(DEPTH)+1 bits wide, wrap at DEPTH. Full when pointers differ only in MSB; empty when equal.
- Push: rx_ready=1 and not (DROP_ERRORS && rx_error) and not full → store {rx_error, rx_data}; write pointer +1.
- Pop: m_valid && m_ready → read pointer +1.
- Push while full: the word is dropped, overflow set, overflow_count +1 (saturate at all-ones). The only exception is a pop in the same cycle; then both happen and there is no overflow. Level is unchanged.
- Simultaneous push and pop while non-full: both occur, level unchanged.
- Output is first-word-fall-through from a registered head stage.
  - m_data/m_error/m_valid are registered outputs.
  - Empty FIFO, rx_ready at cycle N → m_valid=1 at cycle N+2. There is no combinational bypass.
  - m_data/m_error hold stable while m_valid && !m_ready.
  - After a pop, the next word, if present, appears the following cycle. Back-to-back pops sustain 1 word/clk.
- level counts every held entry, including the head stage. It is registered and reflects pushes/pops one cycle after the edge that performs them. Range 0..DEPTH.
- rts_n state machine, two states, registered from level:
  - ASSERTED (rts_n=0) → HOLD (rts_n=1) when level >= RTS_HIGH.
  - HOLD → ASSERTED when level <= RTS_LOW.
  - Otherwise hold current state.
- error_count increments on rx_ready && rx_error regardless of DROP_ERRORS or full. It saturates.
- clear_stats coincident with an incrementing event: the clear wins, and the counter reads 0.
- rx_ready with rx_error=0 never affects error_count. rx_data is ignored when rx_ready=0.

Decomposition:
- Shared package/include: localparam helpers for the pointer width ($clog2(DEPTH)+1) and the entry width (DATA_WIDTH+1). Statistic counter width default defined alongside the existing UART config width constants.
- One natural sub-module: uart_sat_counter (saturating counter with synchronous clear and increment enable). It is instantiated twice, for overflow_count and error_count.
- Storage array and head stage stay inline.

Test Plan:
- Single word: rx_data=0xA5, rx_ready pulse at cycle 10, m_ready=0 → m_valid=1, m_data=0xA5, m_error=0 at cycle 12. The word holds while m_ready=0. Pulse m_ready → m_valid=0 next cycle, level 0.
- Fill to overflow, DEPTH=16: push 0x00..0x10 (17 words), m_ready=0 → level=16, overflow=1, overflow_count=1. Drain → words 0x00..0x0F in order, 0x10 absent.
- RTS hysteresis (RTS_HIGH=12, RTS_LOW=8): push 12 words → rts_n=1. Pop 3 (level 9) → rts_n still 1. Pop 1 (level 8) → rts_n=0.
- Error tagging: DROP_ERRORS=0, push 0x3C with rx_error=1 → m_error=1, error_count=1. With DROP_ERRORS=1, same stimulus → no m_valid, level 0, error_count=1.
- Full plus simultaneous push/pop: level=16, m_ready=1 and rx_ready=1 (0x77) in the same cycle → no overflow, level stays 16, 0x77 emerges last.
- Reset mid-stream and clear precedence:
  - 5 words buffered, assert rst one cycle → m_valid=0, level 0, counters 0, rts_n=0.
  - clear_stats coincident with an overflow event → overflow_count=0, overflow=0.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART width constants, sizing helpers and RTS state type
package uart_rx_fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_STAT_WIDTH = 8;

    typedef enum logic {RTS_ASSERTED, RTS_HOLD} rts_state_e;

    // Pointer carries one extra wrap bit so full and empty are distinguishable
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Each entry stores the data word plus its parity-error tag
    function automatic int entry_w(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// uart_sat_counter: saturating up-counter with synchronous clear and increment enable
module uart_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear beats a coincident increment; counting stops at all-ones
    always_ff @(posedge clk)
        count <= (rst || clr) ? '0 : (inc && count != {WIDTH{1'b1}}) ? count + 1'b1 : count;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer with FWFT registered head, RTS hysteresis and saturating stats
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int DEPTH       = 16,
    parameter int RTS_HIGH    = 12,
    parameter int RTS_LOW     = 8,
    parameter int DROP_ERRORS = 0,
    parameter int STAT_WIDTH  = UART_STAT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_ready,
    input  logic                     rx_error,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_error,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rts_n,
    output logic                     overflow,
    output logic [STAT_WIDTH-1:0]    overflow_count,
    output logic [STAT_WIDTH-1:0]    error_count,
    input  logic                     clear_stats
);

    localparam int PW = ptr_w(DEPTH);
    localparam int EW = entry_w(DATA_WIDTH);
    localparam int AW = PW - 1;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic          full, empty, pop, accept, push, ovf_evt, err_evt;
    rts_state_e    rts_state;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = wr_ptr == rd_ptr;
    assign pop     = m_valid && m_ready;
    assign accept  = rx_ready && !(DROP_ERRORS != 0 && rx_error);
    assign push    = accept && (!full || pop);
    assign ovf_evt = accept && full && !pop;
    assign err_evt = rx_ready && rx_error;
    assign rd_next = rd_ptr + 1'b1;

    // Storage write; when full a same-cycle pop frees the slot being overwritten
    always_ff @(posedge clk)
        if (!rst && push) mem[wr_ptr[AW-1:0]] <= {rx_error, rx_data};

    // Pointers, level and the registered head stage; head mirrors mem[rd_ptr] when valid
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_error <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            level <= level + PW'(push) - PW'(pop);
            if (pop) begin
                rd_ptr  <= rd_next;
                m_valid <= rd_next != wr_ptr;
                if (rd_next != wr_ptr) {m_error, m_data} <= mem[rd_next[AW-1:0]];
            end else if (!m_valid && !empty) begin
                m_valid <= 1'b1;
                {m_error, m_data} <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // RTS hysteresis: hold off at or above the high mark, release at or below the low mark
    always_ff @(posedge clk) begin
        if (rst) begin
            rts_state <= RTS_ASSERTED;
            rts_n     <= 1'b0;
        end else if (rts_state == RTS_ASSERTED && level >= PW'(RTS_HIGH)) begin
            rts_state <= RTS_HOLD;
            rts_n     <= 1'b1;
        end else if (rts_state == RTS_HOLD && level <= PW'(RTS_LOW)) begin
            rts_state <= RTS_ASSERTED;
            rts_n     <= 1'b0;
        end
    end

    // Sticky overflow flag; clear_stats wins over a coincident overflow
    always_ff @(posedge clk)
        overflow <= (rst || clear_stats) ? 1'b0 : (ovf_evt ? 1'b1 : overflow);

    uart_sat_counter #(.WIDTH(STAT_WIDTH)) u_ovf_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_stats),
        .inc   (ovf_evt),
        .count (overflow_count)
    );

    uart_sat_counter #(.WIDTH(STAT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_stats),
        .inc   (err_evt),
        .count (error_count)
    );

endmodule
